// File: rtl/alu_operand_b_stage.sv
// Registered ALU operand-B select with a valid/ready output register.
// Define ALU_OPERAND_B_SKID_EN to add a one-entry skid buffer and register in_ready.
module alu_operand_b_stage #(
    parameter int WIDTH     = 32,
    parameter int IMM_WIDTH = 16,
    parameter int CONST_VAL = 4,
    parameter int SHAMT     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           sel,
    input  logic [WIDTH-1:0]     reg_b,
    input  logic [IMM_WIDTH-1:0] imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 err,
    input  logic                 clear_err
);

    // Modes 110/111 are illegal and yield a zero operand.
    function automatic logic [WIDTH-1:0] form_operand(
        input logic [2:0]           s,
        input logic [WIDTH-1:0]     rb,
        input logic [IMM_WIDTH-1:0] im
    );
        logic signed [WIDTH-1:0] sext;
        logic        [WIDTH-1:0] zext;
        sext = {{(WIDTH-IMM_WIDTH){im[IMM_WIDTH-1]}}, im};
        zext = {{(WIDTH-IMM_WIDTH){1'b0}}, im};
        case (s)
            3'b000:  form_operand = rb;
            3'b001:  form_operand = WIDTH'(CONST_VAL);
            3'b010:  form_operand = $unsigned(sext);
            3'b011:  form_operand = $unsigned(sext <<< SHAMT);
            3'b100:  form_operand = zext;
            3'b101:  form_operand = zext << 16;
            default: form_operand = '0;
        endcase
    endfunction

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             err_q, err_d;
    logic             accept, transfer, illegal;
    logic [WIDTH-1:0] operand;

    assign operand  = form_operand(sel, reg_b, imm);
    assign illegal  = (sel[2:1] == 2'b11);
    assign accept   = in_valid && in_ready;
    assign transfer = out_valid_q && out_ready;

`ifdef ALU_OPERAND_B_SKID_EN
    logic             skid_full_q, skid_full_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;

    // in_ready comes straight from a flop, so out_ready never reaches it.
    assign in_ready = !skid_full_q;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        skid_full_d = skid_full_q;
        skid_data_d = skid_data_q;
        if (!out_valid_q) begin
            if (accept) begin
                out_valid_d = 1'b1;
                out_data_d  = operand;
            end
        end else if (out_ready) begin
            if (skid_full_q) begin
                out_data_d  = skid_data_q;
                skid_full_d = accept;
                if (accept) skid_data_d = operand;
            end else if (accept) begin
                out_data_d  = operand;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_full_d = 1'b1;
            skid_data_d = operand;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) skid_full_q <= 1'b0;
        else       skid_full_q <= skid_full_d;
    end

    always_ff @(posedge clk) begin
        skid_data_q <= skid_data_d;
    end
`else
    assign in_ready = !out_valid_q || out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = operand;
        end else if (transfer) begin
            out_valid_d = 1'b0;
        end
    end
`endif

    // Sticky error: a new illegal accept wins over a simultaneous clear.
    always_comb begin
        err_d = err_q;
        if (accept && illegal) err_d = 1'b1;
        else if (clear_err)    err_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_operand_b_stage.sv
// Self-checking bench for alu_operand_b_stage: vector table, hand sequences and a
// queue-based reference model driven by random traffic.
module tb_alu_operand_b_stage;

    localparam int WIDTH     = 32;
    localparam int IMM_WIDTH = 16;
    localparam int CONST_VAL = 4;
    localparam int SHAMT     = 2;
`ifdef ALU_OPERAND_B_SKID_EN
    localparam int BP_ACCEPTS = 2;
`else
    localparam int BP_ACCEPTS = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready, err, clear_err;
    logic [2:0]  sel;
    logic [31:0] reg_b, out_data;
    logic [15:0] imm;

    int errors = 0;
    int checks = 0;

    logic [31:0] q[$];
    bit          err_m;
    bit          prev_pend;
    logic [2:0]  sel_s;
    logic [31:0] rb_s;
    logic [15:0] imm_s;

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] rb;
        logic [15:0] imm;
        logic [31:0] exp;
    } vec_t;

    alu_operand_b_stage #(
        .WIDTH(WIDTH), .IMM_WIDTH(IMM_WIDTH), .CONST_VAL(CONST_VAL), .SHAMT(SHAMT)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .reg_b(reg_b), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .err(err), .clear_err(clear_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Operand rules evaluated on plain integers.
    function automatic logic [31:0] ref_op(logic [2:0] s, logic [31:0] rb, logic [15:0] im);
        longint zv, sv, r;
        zv = longint'(im);
        sv = (zv >= (longint'(1) << (IMM_WIDTH - 1))) ? zv - (longint'(1) << IMM_WIDTH) : zv;
        case (s)
            3'd0:    r = longint'(rb);
            3'd1:    r = CONST_VAL;
            3'd2:    r = sv;
            3'd3:    r = sv * (longint'(1) << SHAMT);
            3'd4:    r = zv;
            3'd5:    r = zv * 65536;
            default: r = 0;
        endcase
        return r[31:0];
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        err_m     = 1'b0;
        prev_pend = 1'b0;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clear_err = 1'b0;
        sel       = '0;
        reg_b     = '0;
        imm       = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    // One clock: compare at the falling edge, then advance the model over the rising edge.
    task automatic step(output bit dacc, output bit dtrn);
        bit er;
`ifdef ALU_OPERAND_B_SKID_EN
        logic r0;
`endif
        @(negedge clk);
        if (prev_pend)
            assert (in_valid && sel == sel_s && reg_b == rb_s && imm == imm_s)
            else $error("held-input rule broken by stimulus");
`ifdef ALU_OPERAND_B_SKID_EN
        er = (q.size() < 2);
`else
        er = (q.size() == 0) || out_ready;
`endif
        chk("in_ready", in_ready, er);
        chk("out_valid", out_valid, q.size() > 0);
        if (q.size() > 0) chk("out_data", out_data, q[0]);
        chk("err", err, err_m);
`ifdef ALU_OPERAND_B_SKID_EN
        r0 = in_ready;
        out_ready = ~out_ready;
        #1 chk("in_ready_indep_of_out_ready", in_ready, r0);
        out_ready = ~out_ready;
        #1;
`endif
        dacc = in_valid && in_ready;
        dtrn = out_valid && out_ready;
        prev_pend = in_valid && !er;
        sel_s = sel; rb_s = reg_b; imm_s = imm;
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (in_valid && er) begin
            q.push_back(ref_op(sel, reg_b, imm));
            if (sel[2:1] == 2'b11) err_m = 1'b1;
            else if (clear_err)    err_m = 1'b0;
        end else if (clear_err) begin
            err_m = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t        vt[10];
        logic [31:0] bp[3];
        bit          a, t;
        int          idx, nacc, ntr, cyc, n;

        vt[0] = '{3'b000, 32'hDEADBEEF, 16'h8001, 32'hDEADBEEF};
        vt[1] = '{3'b001, 32'hDEADBEEF, 16'h8001, 32'h00000004};
        vt[2] = '{3'b010, 32'hDEADBEEF, 16'h8001, 32'hFFFF8001};
        vt[3] = '{3'b011, 32'hDEADBEEF, 16'h8001, 32'hFFFE0004};
        vt[4] = '{3'b100, 32'hDEADBEEF, 16'h8001, 32'h00008001};
        vt[5] = '{3'b101, 32'hDEADBEEF, 16'h8001, 32'h80010000};
        vt[6] = '{3'b010, 32'h00000000, 16'h7FFF, 32'h00007FFF};
        vt[7] = '{3'b011, 32'h00000000, 16'hFFFF, 32'hFFFFFFFC};
        vt[8] = '{3'b100, 32'h12345678, 16'hFFFF, 32'h0000FFFF};
        vt[9] = '{3'b101, 32'h12345678, 16'hFFFF, 32'hFFFF0000};

        // Reset state and mode sweep
        do_reset();
        chk("reset_out_data", out_data, 32'h0);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_err", err, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            sel = vt[i].sel; reg_b = vt[i].rb; imm = vt[i].imm;
            step(a, t);
            chk($sformatf("vec%0d", i), out_data, vt[i].exp);
        end
        in_valid = 1'b0;
        step(a, t);

        // Illegal mode, sticky err, clear, and set-beats-clear
        in_valid = 1'b1; sel = 3'b110; imm = 16'h1234; reg_b = 32'hA5A5A5A5;
        step(a, t);
        in_valid = 1'b0;
        chk("illegal_valid", out_valid, 1'b1);
        chk("illegal_data", out_data, 32'h0);
        chk("illegal_err", err, 1'b1);
        step(a, t);
        step(a, t);
        clear_err = 1'b1;
        step(a, t);
        clear_err = 1'b0;
        chk("err_cleared", err, 1'b0);
        in_valid = 1'b1; sel = 3'b111; clear_err = 1'b1;
        step(a, t);
        in_valid = 1'b0; clear_err = 1'b0;
        chk("err_set_wins", err, 1'b1);
        step(a, t);

        // Backpressure with three queued beats
        do_reset();
        bp[0] = 32'hAAAA0001; bp[1] = 32'hBBBB0002; bp[2] = 32'hCCCC0003;
        idx = 0; nacc = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = (idx < 3);
            sel = 3'b000; reg_b = bp[idx < 3 ? idx : 2]; imm = 16'h0;
            if (c == 2) chk("bp_in_ready_c3", in_ready, 1'b0);
            step(a, t);
            if (a) begin nacc++; idx++; end
            chk("bp_hold", out_data, bp[0]);
        end
        chk("bp_accepts", nacc, BP_ACCEPTS);
        out_ready = 1'b1; ntr = 0; cyc = 0;
        while (ntr < 3 && cyc < 20) begin
            in_valid = (idx < 3);
            reg_b = bp[idx < 3 ? idx : 2];
            step(a, t);
            if (a) idx++;
            if (t) ntr++;
            cyc++;
        end
        chk("bp_no_gaps", cyc, 3);
        in_valid = 1'b0;
        step(a, t);

        // Random streaming against the model
        do_reset();
        n = 0; cyc = 0;
        in_valid = 1'b1;
        sel = 3'($urandom_range(0, 7)); reg_b = $urandom; imm = 16'($urandom);
        while ((n < 100 || q.size() > 0) && cyc < 3000) begin
            out_ready = 1'($urandom_range(0, 1));
            clear_err = ($urandom_range(0, 15) == 0);
            step(a, t);
            if (a) begin
                n++;
                if (n < 100) begin
                    sel = 3'($urandom_range(0, 7)); reg_b = $urandom; imm = 16'($urandom);
                end else begin
                    in_valid = 1'b0;
                end
            end
            cyc++;
        end
        clear_err = 1'b0;
        chk("stream_beats", n, 100);
        chk("stream_drained", q.size(), 0);

        // Reset while the stage holds data
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; sel = 3'b110; imm = 16'h0;
        step(a, t);
        in_valid = (BP_ACCEPTS == 2); sel = 3'b000; reg_b = 32'h11111111;
        step(a, t);
        in_valid = 1'b0;
        chk("pre_reset_valid", out_valid, 1'b1);
        chk("pre_reset_err", err, 1'b1);
        reset = 1'b1;
        #1;
        chk("mid_reset_valid", out_valid, 1'b0);
        chk("mid_reset_err", err, 1'b0);
        chk("mid_reset_data", out_data, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; sel = 3'b000; reg_b = 32'hCAFEF00D;
        step(a, t);
        in_valid = 1'b0;
        chk("post_reset_valid", out_valid, 1'b1);
        chk("post_reset_data", out_data, 32'hCAFEF00D);
        step(a, t);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
